biu_arbiter: RTL



---
 rtl/biu_pkg.sv | 15 +
 rtl/biu_if.sv | 31 +++
 rtl/biu_rr_arbiter.sv | 40 ++++
 rtl/biu_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types and constants for the two-master bus interface unit.
package biu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } biu_state_t;

  typedef logic biu_master_id_t;

  localparam int BIU_NUM_MASTERS = 2;

endpackage

// File: rtl/biu_if.sv
// Master-side and slave-side bus interfaces; the biu modport is the view the arbiter core uses.
interface biu_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_in;

  modport biu (input en, rnw, address, data_out, output busy, data_valid, data_in);
  modport dev (output en, rnw, address, data_out, input busy, data_valid, data_in);
endinterface

interface biu_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_in;

  modport biu (output en, rnw, address, data_out, input data_valid, data_in);
  modport dev (input en, rnw, address, data_out, output data_valid, data_in);
endinterface

// File: rtl/biu_rr_arbiter.sv
// Two-requester round-robin arbiter. last_grant_o also serves as the current owner,
// since it is rewritten on every grant.
module biu_rr_arbiter
  import biu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIU_NUM_MASTERS-1:0] req_i,
  input  logic                       gnt_en_i,
  output logic [BIU_NUM_MASTERS-1:0] grant_o,
  output biu_master_id_t             last_grant_o
);

  biu_master_id_t last_grant_q;

  // On contention, favour the master that did not win last time.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Reset to master 1 so that master 0 wins the first contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (gnt_en_i && (req_i != 2'b00)) begin
      last_grant_q <= grant_o[1];
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/biu_arbiter.sv
// Bus interface unit core: arbitrates two masters onto one slave, one transaction at a time,
// with a bounded wait for read data.
module biu_arbiter
  import biu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic      clk,
  input  logic      rst,
  biu_master_if.biu m0,
  biu_master_if.biu m1,
  biu_slave_if.biu  s,
  output logic      timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  biu_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       rnw_q, rnw_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       s_en_q;
  logic                       busy_q;
  logic [1:0]                 dv_q;
  logic                       terr_q;
  logic [BIU_NUM_MASTERS-1:0] req_s;
  logic [BIU_NUM_MASTERS-1:0] grant_s;
  logic                       gnt_en_s;
  biu_master_id_t             owner_s;

  assign req_s = {m1.en, m0.en};

  biu_rr_arbiter u_rr (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_s),
    .gnt_en_i     (gnt_en_s),
    .grant_o      (grant_s),
    .last_grant_o (owner_s)
  );

  // Transaction sequencing: accept, issue, wait for read data (bounded), report.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rnw_d    = rnw_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    gnt_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s != 2'b00) begin
          gnt_en_s = 1'b1;
          state_d  = ISSUE;
          if (grant_s[1]) begin
            addr_d  = m1.address;
            wdata_d = m1.data_out;
            rnw_d   = m1.rnw;
          end else begin
            addr_d  = m0.address;
            wdata_d = m0.data_out;
            rnw_d   = m0.rnw;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!rnw_q) begin
          state_d = DONE;
        end else if (s.data_valid) begin
          rdata_d = s.data_in;
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s.data_valid) begin
          rdata_d = s.data_in;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = {DATA_WIDTH{1'b1}};
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State plus output registers; outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      s_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      dv_q    <= 2'b00;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rnw_q   <= rnw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      s_en_q  <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      dv_q    <= {(state_d == DONE) && owner_s, (state_d == DONE) && !owner_s};
      terr_q  <= (state_d == DONE) && err_d;
    end
  end

  assign s.en          = s_en_q;
  assign s.rnw         = rnw_q;
  assign s.address     = addr_q;
  assign s.data_out    = wdata_q;
  assign m0.busy       = busy_q;
  assign m1.busy       = busy_q;
  assign m0.data_valid = dv_q[0];
  assign m1.data_valid = dv_q[1];
  assign m0.data_in    = rdata_q;
  assign m1.data_in    = rdata_q;
  assign timeout_err   = terr_q;

endmodule
